// File: rtl/n64a_vinfo_ext_pkg.sv
// Shared constants for the N64 video-info block: sync word bit positions,
// RGB slot encodings, arm FSM states and demux parameter bus layout.
package n64a_vinfo_ext_pkg;

  localparam int VSYNC_IDX = 3;
  localparam int CLAMP_IDX = 2;
  localparam int HSYNC_IDX = 1;
  localparam int CSYNC_IDX = 0;

  localparam logic [1:0] DC_RED   = 2'b01;
  localparam logic [1:0] DC_GREEN = 2'b10;
  localparam logic [1:0] DC_BLUE  = 2'b11;

  localparam int LINE_CNT_W_DEF        = 10;
  localparam int VMODE_LINE_THRESH_DEF = 287;

  typedef enum logic [1:0] {
    ARM_IDLE  = 2'b00,
    ARM_ARMED = 2'b01,
    ARM_RUN   = 2'b10
  } arm_state_t;

  // Demux parameter bus layout as packed by the parent
  localparam int PBUS_DATA_CNT_LSB = 0;
  localparam int PBUS_DATA_CNT_MSB = 1;
  localparam int PBUS_VMODE_IDX    = 2;
  localparam int PBUS_480I_IDX     = 3;
  localparam int PBUS_DEBLUR_IDX   = 4;
  localparam int PBUS_15BIT_IDX    = 5;
  localparam int PBUS_W            = 6;

  // Slot index for the next VD cycle: restart at red after a sync word.
  function automatic logic [1:0] dc_next(input logic sync_cyc, input logic [1:0] dc);
    if (sync_cyc) return DC_RED;
    return 2'(dc + 2'd1);
  endfunction

endpackage

// File: rtl/n64a_vinfo_linecnt.sv
// Sync word edge detection and saturating line counter; emits a vsync
// strobe together with the completed line count of the ending field.
module n64a_vinfo_linecnt
  import n64a_vinfo_ext_pkg::*;
#(
  parameter int LINE_CNT_W = LINE_CNT_W_DEF
)(
  input  logic                  VCLK,
  input  logic                  nRST,
  input  logic                  nVDSYNC_i,
  input  logic [3:0]            Sync_i,
  output logic                  vsync_stb,
  output logic [LINE_CNT_W-1:0] line_c
);

  logic [3:0]            sync_prev;
  logic [LINE_CNT_W-1:0] line_cnt;
  logic [LINE_CNT_W-1:0] line_cnt_inc;
  logic                  sync_cyc;
  logic                  hs_fall;
  logic                  vs_fall;
  logic                  unused_sync_bits;

  assign sync_cyc = ~nVDSYNC_i;
  assign hs_fall  = sync_cyc & sync_prev[HSYNC_IDX] & ~Sync_i[HSYNC_IDX];
  assign vs_fall  = sync_cyc & sync_prev[VSYNC_IDX] & ~Sync_i[VSYNC_IDX];

  // A line ending on the vsync sample is counted before the clear.
  assign line_cnt_inc = (hs_fall && (line_cnt != '1)) ? line_cnt + LINE_CNT_W'(1) : line_cnt;

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      sync_prev <= 4'hF;
      line_cnt  <= '0;
    end else begin
      if (sync_cyc)
        sync_prev <= Sync_i;
      line_cnt <= vs_fall ? '0 : line_cnt_inc;
    end
  end

  assign vsync_stb = vs_fall;
  assign line_c    = line_cnt_inc;

  assign unused_sync_bits = ^{sync_prev[CLAMP_IDX], sync_prev[CSYNC_IDX]};

endmodule

// File: rtl/n64a_vinfo_ext.sv
// N64 video info: RGB slot counter plus PAL/NTSC, 480i and field ID flags.
// Optional macro VINFO_STABLE_FILTER_EN debounces vmode/480i over two fields.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARM_IDLE  | after reset; first field count is partial and discarded
// ARM_ARMED | one valid field boundary seen; next count sets vmode
// ARM_RUN   | previous count held; every field updates vmode/480i/fid
module n64a_vinfo_ext
  import n64a_vinfo_ext_pkg::*;
#(
  parameter int                    LINE_CNT_W        = LINE_CNT_W_DEF,
  parameter logic [LINE_CNT_W-1:0] VMODE_LINE_THRESH = LINE_CNT_W'(VMODE_LINE_THRESH_DEF)
)(
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nVDSYNC_i,
  input  logic [3:0] Sync_i,
  output logic [1:0] data_cnt_o,
  output logic       vmode_o,
  output logic       n64_480i_o,
  output logic       field_id_o
);

  logic                  vsync_stb;
  logic [LINE_CNT_W-1:0] line_c;

  arm_state_t            arm_state, arm_nx;
  logic [LINE_CNT_W-1:0] prev_c, prev_c_nx;
  logic                  vmode_nx, i480_nx, fid_nx;
  logic                  vmode_eval, i480_eval;

`ifdef VINFO_STABLE_FILTER_EN
  logic vmode_pend, vmode_pend_nx, vmode_pv, vmode_pv_nx;
  logic i480_pend, i480_pend_nx, i480_pv, i480_pv_nx;
`endif

  n64a_vinfo_linecnt #(
    .LINE_CNT_W(LINE_CNT_W)
  ) u_linecnt (
    .VCLK      (VCLK),
    .nRST      (nRST),
    .nVDSYNC_i (nVDSYNC_i),
    .Sync_i    (Sync_i),
    .vsync_stb (vsync_stb),
    .line_c    (line_c)
  );

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      data_cnt_o <= 2'b00;
      arm_state  <= ARM_IDLE;
      prev_c     <= '0;
      vmode_o    <= 1'b0;
      n64_480i_o <= 1'b0;
      field_id_o <= 1'b0;
`ifdef VINFO_STABLE_FILTER_EN
      vmode_pend <= 1'b0;
      vmode_pv   <= 1'b0;
      i480_pend  <= 1'b0;
      i480_pv    <= 1'b0;
`endif
    end else begin
      data_cnt_o <= dc_next(~nVDSYNC_i, data_cnt_o);
      arm_state  <= arm_nx;
      prev_c     <= prev_c_nx;
      vmode_o    <= vmode_nx;
      n64_480i_o <= i480_nx;
      field_id_o <= fid_nx;
`ifdef VINFO_STABLE_FILTER_EN
      vmode_pend <= vmode_pend_nx;
      vmode_pv   <= vmode_pv_nx;
      i480_pend  <= i480_pend_nx;
      i480_pv    <= i480_pv_nx;
`endif
    end
  end

  always_comb begin
    arm_nx     = arm_state;
    prev_c_nx  = prev_c;
    vmode_nx   = vmode_o;
    i480_nx    = n64_480i_o;
    fid_nx     = field_id_o;
    vmode_eval = (line_c > VMODE_LINE_THRESH);
    i480_eval  = (line_c != prev_c);
`ifdef VINFO_STABLE_FILTER_EN
    vmode_pend_nx = vmode_pend;
    vmode_pv_nx   = vmode_pv;
    i480_pend_nx  = i480_pend;
    i480_pv_nx    = i480_pv;
`endif

    if (vsync_stb) begin
      // A saturated count means the field boundary was lost: re-arm, hold flags.
      if (line_c == '1) begin
        arm_nx = ARM_ARMED;
`ifdef VINFO_STABLE_FILTER_EN
        vmode_pv_nx = 1'b0;
        i480_pv_nx  = 1'b0;
`endif
      end else begin
        unique case (arm_state)
          ARM_IDLE: begin
            arm_nx = ARM_ARMED;
          end
          ARM_ARMED: begin
            arm_nx    = ARM_RUN;
            vmode_nx  = vmode_eval;
            prev_c_nx = line_c;
`ifdef VINFO_STABLE_FILTER_EN
            vmode_pv_nx = 1'b0;
            i480_pv_nx  = 1'b0;
`endif
          end
          ARM_RUN: begin
            prev_c_nx = line_c;
`ifdef VINFO_STABLE_FILTER_EN
            // A new value must be seen on two consecutive fields before it sticks.
            if (vmode_eval == vmode_o) begin
              vmode_pv_nx = 1'b0;
            end else if (vmode_pv && (vmode_pend == vmode_eval)) begin
              vmode_nx    = vmode_eval;
              vmode_pv_nx = 1'b0;
            end else begin
              vmode_pend_nx = vmode_eval;
              vmode_pv_nx   = 1'b1;
            end
            if (i480_eval == n64_480i_o) begin
              i480_pv_nx = 1'b0;
            end else if (i480_pv && (i480_pend == i480_eval)) begin
              i480_nx    = i480_eval;
              i480_pv_nx = 1'b0;
            end else begin
              i480_pend_nx = i480_eval;
              i480_pv_nx   = 1'b1;
            end
`else
            vmode_nx = vmode_eval;
            i480_nx  = i480_eval;
`endif
            fid_nx = i480_nx ? ~field_id_o : 1'b0;
          end
          default: begin
            arm_nx = ARM_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n64a_vinfo_ext.sv
// Self-checking bench for n64a_vinfo_ext: randomized sync word stream
// compared every cycle against a field-level reference model.
module tb_n64a_vinfo_ext;

  logic       VCLK;
  logic       nRST;
  logic       nVDSYNC_i;
  logic [3:0] Sync_i;
  logic [1:0] data_cnt_o;
  logic       vmode_o;
  logic       n64_480i_o;
  logic       field_id_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_lines;
  int m_good;
  int m_prevc;
  int m_dc;
  bit m_vmode, m_i480, m_fid;
  bit m_prev_h, m_prev_v;

  n64a_vinfo_ext dut (
    .VCLK       (VCLK),
    .nRST       (nRST),
    .nVDSYNC_i  (nVDSYNC_i),
    .Sync_i     (Sync_i),
    .data_cnt_o (data_cnt_o),
    .vmode_o    (vmode_o),
    .n64_480i_o (n64_480i_o),
    .field_id_o (field_id_o)
  );

  initial VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lines  = 0;
    m_good   = 0;
    m_prevc  = 0;
    m_dc     = 0;
    m_vmode  = 0;
    m_i480   = 0;
    m_fid    = 0;
    m_prev_h = 1;
    m_prev_v = 1;
  endtask

  // Field-level rules: first boundary after reset/loss is discarded, the
  // next one sets PAL/NTSC, later ones also compare with the previous count.
  task automatic model_field(input int c);
    if (c == 1023 || m_good == 0) begin
      m_good = 1;
    end else if (m_good == 1) begin
      m_vmode = (c > 287);
      m_prevc = c;
      m_good  = 2;
    end else begin
      m_vmode = (c > 287);
      m_i480  = (c != m_prevc);
      m_fid   = m_i480 ? !m_fid : 1'b0;
      m_prevc = c;
    end
  endtask

  task automatic model_step(input logic r, input logic nvd, input logic [3:0] s);
    bit hf, vf;
    int c;
    if (!r) begin
      model_reset();
    end else if (!nvd) begin
      hf = m_prev_h && !s[1];
      vf = m_prev_v && !s[3];
      m_prev_h = s[1];
      m_prev_v = s[3];
      if (hf && m_lines < 1023) m_lines++;
      if (vf) begin
        c = m_lines;
        m_lines = 0;
        model_field(c);
      end
      m_dc = 1;
    end else begin
      m_dc = (m_dc + 1) % 4;
    end
  endtask

  task automatic tick();
    logic       r;
    logic       nvd;
    logic [3:0] s;
    r   = nRST;
    nvd = nVDSYNC_i;
    s   = Sync_i;
    @(posedge VCLK);
    #1;
    model_step(r, nvd, s);
    check_val("data_cnt", 32'(data_cnt_o), 32'(m_dc));
    check_val("vmode", 32'(vmode_o), 32'(m_vmode));
    check_val("n64_480i", 32'(n64_480i_o), 32'(m_i480));
    check_val("field_id", 32'(field_id_o), 32'(m_fid));
  endtask

  task automatic send_word(input logic v, input logic h, input int gap);
    nVDSYNC_i = 1'b0;
    Sync_i    = {v, 1'($urandom), h, 1'($urandom)};
    tick();
    for (int i = 0; i < gap; i++) begin
      nVDSYNC_i = 1'b1;
      Sync_i    = 4'($urandom);
      tick();
    end
  endtask

  task automatic send_line();
    send_word(1'b1, 1'b1, 1);
    if ($urandom_range(0, 15) == 0) send_word(1'b1, 1'b1, 1);
    send_word(1'b1, 1'b0, 1);
    if ($urandom_range(0, 15) == 0) send_word(1'b1, 1'b0, $urandom_range(1, 3));
  endtask

  task automatic send_field(input int n, input bit coinc);
    if (coinc) begin
      for (int i = 0; i < n - 1; i++) send_line();
      send_word(1'b1, 1'b1, 1);
      send_word(1'b0, 1'b0, 1);
    end else begin
      for (int i = 0; i < n; i++) send_line();
      send_word(1'b0, 1'b1, 1);
    end
  endtask

  task automatic do_reset(input int cycles);
    nRST      = 1'b0;
    nVDSYNC_i = 1'b1;
    Sync_i    = 4'hF;
    for (int i = 0; i < cycles; i++) tick();
    check_val("rst_data_cnt", 32'(data_cnt_o), 32'd0);
    check_val("rst_vmode", 32'(vmode_o), 32'd0);
    check_val("rst_480i", 32'(n64_480i_o), 32'd0);
    check_val("rst_fid", 32'(field_id_o), 32'd0);
    nRST = 1'b1;
  endtask

  initial begin
    int lens[4];
    lens = '{262, 263, 312, 313};
    model_reset();
    do_reset(2);

    // Slot counter: sync word every 4 cycles, plus a longer gap to see the wrap
    for (int i = 0; i < 8; i++) send_word(1'b1, 1'b1, 3);
    send_word(1'b1, 1'b1, 5);
    send_word(1'b1, 1'b1, 3);
    check_val("slot_after_gap", 32'(data_cnt_o), 32'd0);

    // NTSC progressive
    send_field(262, 0);
    check_val("ntsc_vs1_vmode", 32'(vmode_o), 32'd0);
    for (int i = 0; i < 3; i++) send_field(262, 0);
    check_val("ntsc_prog_vmode", 32'(vmode_o), 32'd0);
    check_val("ntsc_prog_480i", 32'(n64_480i_o), 32'd0);
    check_val("ntsc_prog_fid", 32'(field_id_o), 32'd0);

    // PAL, then PAL interlaced
    do_reset(1);
    send_field(312, 0);
    check_val("pal_vs1_vmode", 32'(vmode_o), 32'd0);
    send_field(312, 0);
    check_val("pal_vs2_vmode", 32'(vmode_o), 32'd1);
    check_val("pal_vs2_480i", 32'(n64_480i_o), 32'd0);
    send_field(313, 0);
    check_val("pal_vs3_480i", 32'(n64_480i_o), 32'd1);
    check_val("pal_vs3_fid", 32'(field_id_o), 32'd1);
    send_field(312, 0);
    check_val("pal_vs4_fid", 32'(field_id_o), 32'd0);
    send_field(313, 0);
    check_val("pal_vs5_fid", 32'(field_id_o), 32'd1);

    // NTSC interlaced, then constant 263
    send_field(262, 0);
    check_val("ntsci_vmode", 32'(vmode_o), 32'd0);
    send_field(263, 0);
    send_field(262, 0);
    send_field(263, 0);
    check_val("ntsci_480i", 32'(n64_480i_o), 32'd1);
    send_field(263, 0);
    check_val("ntsc_const_480i", 32'(n64_480i_o), 32'd0);
    check_val("ntsc_const_fid", 32'(field_id_o), 32'd0);

    // Hsync and vsync falling in the same sample
    send_field(262, 0);
    send_field(262, 0);
    send_field(262, 1);
    check_val("coinc_480i", 32'(n64_480i_o), 32'd0);
    send_field(313, 1);
    check_val("coinc_pal_vmode", 32'(vmode_o), 32'd1);
    check_val("coinc_pal_480i", 32'(n64_480i_o), 32'd1);

    // Counter saturation without vsync
    for (int i = 0; i < 1100; i++) send_line();
    check_val("sat_hold_vmode", 32'(vmode_o), 32'd1);
    check_val("sat_hold_480i", 32'(n64_480i_o), 32'd1);
    send_word(1'b0, 1'b1, 1);
    check_val("sat_vs_vmode", 32'(vmode_o), 32'd1);
    check_val("sat_vs_480i", 32'(n64_480i_o), 32'd1);
    send_field(262, 0);
    check_val("sat_rearm_vmode", 32'(vmode_o), 32'd0);
    check_val("sat_rearm_480i", 32'(n64_480i_o), 32'd1);
    send_field(262, 0);
    check_val("sat_run_480i", 32'(n64_480i_o), 32'd0);

    // Reset in the middle of a PAL field
    send_field(312, 0);
    send_field(312, 0);
    check_val("pre_rst_vmode", 32'(vmode_o), 32'd1);
    begin
      int part;
      part = $urandom_range(50, 150);
      for (int i = 0; i < part; i++) send_line();
      do_reset(1);
      for (int i = 0; i < 312 - part; i++) send_line();
      send_word(1'b0, 1'b1, 1);
    end
    check_val("post_rst_vs1_vmode", 32'(vmode_o), 32'd0);
    send_field(312, 0);
    check_val("post_rst_vs2_vmode", 32'(vmode_o), 32'd1);

    // Random field sequence
    for (int i = 0; i < 8; i++) send_field(lens[$urandom_range(0, 3)], 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
